// File: rtl/lr_check.sv
// Left/right consistency check for a streaming stereo disparity pipeline.
// Right-view disparities fill one of two line banks in ascending x order while
// left-view disparities (alternating direction per line, from a LIFO stage)
// are compared against the matching right pixel. A left pixel at x with
// disparity dL must agree with the right pixel at x-dL within THRESH,
// otherwise it is marked invalid.
module lr_check #(
  parameter int DWIDTH = 11,
  parameter int AWIDTH = 11,
  parameter int MAXW   = 1936,
  parameter int THRESH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [10:0]       width,
  input  logic              dr_valid,
  input  logic [DWIDTH-1:0] dr_in,
  input  logic              dl_valid,
  input  logic [DWIDTH-1:0] dl_in,
  output logic [DWIDTH-1:0] dout,
  output logic              dout_valid,
  output logic [AWIDTH-1:0] dout_x,
  output logic              line_done,
  output logic              ovr_err
);

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

  localparam logic [DWIDTH-1:0] THRESH_V = DWIDTH'(THRESH);

  // Two right-disparity line banks: one being written, one being checked.
  logic [DWIDTH-1:0] bank_mem [2][MAXW];

  // Line bookkeeping.
  logic [AWIDTH-1:0] wx_q, wx_d;
  logic              wb_q, wb_d;
  logic              rb_q, rb_d;
  logic [1:0]        rdy_cnt_q, rdy_cnt_d;
  logic [AWIDTH-1:0] lx_q, lx_d;
  dir_e              dir_q, dir_d;
  logic              ovr_err_q, ovr_err_d;

  // Stage 1.
  logic              v1_q, v1_d;
  logic [DWIDTH-1:0] dl1_q, dl1_d;
  logic [AWIDTH-1:0] x1_q, x1_d;
  logic [AWIDTH:0]   xr1_q, xr1_d;
  logic              oob1_q, oob1_d;
  logic              rb1_q, rb1_d;
  logic              end1_q, end1_d;

  // Stage 2 (registered outputs).
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic [AWIDTH-1:0] dout_x_q, dout_x_d;
  logic              line_done_q, line_done_d;

  logic [AWIDTH-1:0] last_x;
  logic              r_end, l_end;
  logic [AWIDTH-1:0] rd_addr;
  logic [DWIDTH-1:0] rd_data, adiff;

  assign last_x = AWIDTH'(width - 11'd1);
  assign r_end  = dr_valid && (wx_q == last_x);
  assign l_end  = dl_valid && (((dir_q == DIR_DOWN) && (lx_q == '0)) ||
                               ((dir_q == DIR_UP) && (lx_q == last_x)));

  // Next-state for write/read line counters and the stage-1 capture; applied only when clken is high.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned and infers a latch.
    wx_d      = wx_q;
    wb_d      = wb_q;
    rb_d      = rb_q;
    rdy_cnt_d = rdy_cnt_q;
    lx_d      = lx_q;
    dir_d     = dir_q;
    ovr_err_d = ovr_err_q;

    if (dr_valid) begin
      if (r_end) begin
        wx_d = '0;
        wb_d = ~wb_q;
      end else begin
        wx_d = wx_q + AWIDTH'(1);
      end
    end

    if (dl_valid) begin
      if (rdy_cnt_q == 2'd0) ovr_err_d = 1'b1;
      if (l_end) begin
        // The end index is also the first index of the next line, so lx holds.
        dir_d = (dir_q == DIR_DOWN) ? DIR_UP : DIR_DOWN;
        rb_d  = ~rb_q;
      end else if (dir_q == DIR_DOWN) begin
        lx_d = lx_q - AWIDTH'(1);
      end else begin
        lx_d = lx_q + AWIDTH'(1);
      end
    end

    // Simultaneous right and left line ends cancel out.
    case ({r_end, l_end})
      2'b10:   if (rdy_cnt_q != 2'd2) rdy_cnt_d = rdy_cnt_q + 2'd1;
      2'b01:   if (rdy_cnt_q != 2'd0) rdy_cnt_d = rdy_cnt_q - 2'd1;
      default: rdy_cnt_d = rdy_cnt_q;
    endcase

    v1_d   = dl_valid;
    dl1_d  = dl_in;
    x1_d   = lx_q;
    xr1_d  = {1'b0, lx_q} - (AWIDTH+1)'(dl_in);
    oob1_d = (32'(dl_in) > 32'(lx_q));
    rb1_d  = rb_q;
    end1_d = l_end;
  end

  // Stage 2: fetch the matching right disparity and decide valid/invalid.
  always_comb begin
    rd_addr = xr1_q[AWIDTH] ? '0 : xr1_q[AWIDTH-1:0];
    rd_data = bank_mem[rb1_q][rd_addr];
    adiff   = (dl1_q >= rd_data) ? (dl1_q - rd_data) : (rd_data - dl1_q);

    dout_d       = dout_q;
    dout_x_d     = dout_x_q;
    dout_valid_d = v1_q;
    line_done_d  = v1_q && end1_q;
    if (v1_q) begin
      dout_d   = (oob1_q || (adiff > THRESH_V)) ? '1 : dl1_q;
      dout_x_d = x1_q;
    end
  end

  // Control and pipeline registers; everything holds while clken is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wx_q         <= '0;
      wb_q         <= 1'b0;
      rb_q         <= 1'b0;
      rdy_cnt_q    <= 2'd0;
      lx_q         <= last_x;
      dir_q        <= DIR_DOWN;
      ovr_err_q    <= 1'b0;
      v1_q         <= 1'b0;
      dl1_q        <= '0;
      x1_q         <= '0;
      xr1_q        <= '0;
      oob1_q       <= 1'b0;
      rb1_q        <= 1'b0;
      end1_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_x_q     <= '0;
      line_done_q  <= 1'b0;
    end else if (clken) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      wx_q         <= wx_d;
      wb_q         <= wb_d;
      rb_q         <= rb_d;
      rdy_cnt_q    <= rdy_cnt_d;
      lx_q         <= lx_d;
      dir_q        <= dir_d;
      ovr_err_q    <= ovr_err_d;
      v1_q         <= v1_d;
      dl1_q        <= dl1_d;
      x1_q         <= x1_d;
      xr1_q        <= xr1_d;
      oob1_q       <= oob1_d;
      rb1_q        <= rb1_d;
      end1_q       <= end1_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_x_q     <= dout_x_d;
      line_done_q  <= line_done_d;
    end
  end

  // Right pixel writes; a same-cycle read of the same address sees the old word.
  always_ff @(posedge clk) begin
    // NOTE: bank storage has no reset; it is always written before it is meaningfully read.
    if (clken && dr_valid) bank_mem[wb_q][wx_q] <= dr_in;
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_x     = dout_x_q;
  assign line_done  = line_done_q;
  assign ovr_err    = ovr_err_q;

endmodule

// File: tb/tb_lr_check.sv
// Randomised bench for lr_check: a line-level reference model predicts each
// checked pixel from the pixel streams, and a monitor compares on every
// clock-enabled edge, including exact latency and freeze while clken is low.
module tb_lr_check;

  localparam int DW     = 11;
  localparam int AW     = 11;
  localparam int MAXW   = 1936;
  localparam int THRESH = 1;
  localparam int SNW    = DW + AW + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clken = 1'b0;
  logic [10:0]   width = 11'd4;
  logic          dr_valid = 1'b0;
  logic [DW-1:0] dr_in = '0;
  logic          dl_valid = 1'b0;
  logic [DW-1:0] dl_in = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [AW-1:0] dout_x;
  logic          line_done;
  logic          ovr_err;

  lr_check #(.DWIDTH(DW), .AWIDTH(AW), .MAXW(MAXW), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .clken(clken), .width(width),
    .dr_valid(dr_valid), .dr_in(dr_in),
    .dl_valid(dl_valid), .dl_in(dl_in),
    .dout(dout), .dout_valid(dout_valid), .dout_x(dout_x),
    .line_done(line_done), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  // Expected output of one accepted left pixel, due on a given clken edge.
  typedef struct {
    logic [DW-1:0] d;
    int            x;
    bit            last;
    int            due;
  } exp_t;

  exp_t     exp_q[$];
  exp_t     cur;
  int       mbank [2][MAXW];
  int       r_line, r_pos, l_line, l_pos;
  int       m_rdy;
  bit       m_ovr;
  int       ce_cnt;
  int       n_checks;
  int       n_errors;
  logic [SNW-1:0] prev_snap;
  bit       exp_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: on clken edges compare against the model, on frozen edges against the previous outputs.
  always @(posedge clk) begin
    if (rst) begin
      if (clken) begin
        ce_cnt++;
        #1;
        exp_v = (exp_q.size() > 0) && (exp_q[0].due == ce_cnt);
        check("dout_valid", 32'(dout_valid), 32'(exp_v));
        if (exp_v) begin
          cur = exp_q.pop_front();
          check("dout", 32'(dout), 32'(cur.d));
          check("dout_x", 32'(dout_x), 32'(cur.x));
          check("line_done", 32'(line_done), 32'(cur.last));
        end else begin
          check("line_done_idle", 32'(line_done), 32'd0);
        end
        check("ovr_err", 32'(ovr_err), 32'(m_ovr));
      end else begin
        #1;
        check("frozen", 32'({dout, dout_valid, dout_x, line_done, ovr_err}), 32'(prev_snap));
      end
      prev_snap = {dout, dout_valid, dout_x, line_done, ovr_err};
    end
  end

  // One input cycle; the model applies this cycle's right write before predicting the left pixel,
  // because the stage-2 read happens on the following clken edge.
  task automatic drive(input bit ce, input bit rv, input int rd, input bit lv, input int ld);
    int w, x, dr, ad, rdy0;
    bit lend, rend;
    logic [DW-1:0] e;
    w    = int'(width);
    rdy0 = m_rdy;
    lend = 1'b0;
    rend = 1'b0;
    @(negedge clk);
    clken    = ce;
    dr_valid = rv;
    dr_in    = DW'(rd);
    dl_valid = lv;
    dl_in    = DW'(ld);
    if (ce && rv) begin
      mbank[r_line % 2][r_pos] = rd;
      if (r_pos == w - 1) begin
        r_pos = 0;
        r_line++;
        rend = 1'b1;
      end else begin
        r_pos++;
      end
    end
    if (ce && lv) begin
      x = (l_line % 2 == 0) ? (w - 1 - l_pos) : l_pos;
      if (rdy0 == 0) m_ovr = 1'b1;
      if (ld > x) begin
        e = '1;
      end else begin
        dr = mbank[l_line % 2][x - ld];
        ad = (ld > dr) ? (ld - dr) : (dr - ld);
        e  = (ad > THRESH) ? '1 : DW'(ld);
      end
      lend = (l_pos == w - 1);
      exp_q.push_back('{e, x, lend, ce_cnt + 2});
      if (lend) begin
        l_pos = 0;
        l_line++;
      end else begin
        l_pos++;
      end
    end
    if (rend && !lend && m_rdy < 2) m_rdy++;
    else if (lend && !rend && m_rdy > 0) m_rdy--;
  endtask

  // Stream nr right and nl left pixels (4-bit values, nibble i = i-th pixel) with random clken/bubbles.
  task automatic send(input int nr, input logic [63:0] rvals, input int nl, input logic [63:0] lvals,
                      input int ce_pct, input int lv_pct);
    int ri, li;
    bit ce, rv, lv;
    ri = 0;
    li = 0;
    while (ri < nr || li < nl) begin
      ce = ($urandom_range(0, 99) < ce_pct);
      rv = (ri < nr);
      lv = (li < nl) && ($urandom_range(0, 99) < lv_pct);
      drive(ce, rv, int'(rvals[(ri % 16) * 4 +: 4]), lv, int'(lvals[(li % 16) * 4 +: 4]));
      if (ce && rv) ri++;
      if (ce && lv) li++;
    end
  endtask

  task automatic drain();
    repeat (4) drive(1'b1, 1'b0, 0, 1'b0, 0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input int w);
    @(negedge clk);
    rst      = 1'b0;
    clken    = 1'b0;
    dr_valid = 1'b0;
    dl_valid = 1'b0;
    width    = 11'(w);
    exp_q.delete();
    r_line = 0; r_pos = 0; l_line = 0; l_pos = 0;
    m_rdy  = 0;
    m_ovr  = 1'b0;
    #1;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_dout_x", 32'(dout_x), 32'd0);
    check("rst_line_done", 32'(line_done), 32'd0);
    check("rst_ovr_err", 32'(ovr_err), 32'd0);
    repeat (2) @(negedge clk);
    prev_snap = '0;
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] rv, lv;
    n_checks = 0;
    n_errors = 0;
    ce_cnt   = 0;

    // Width 4: right line 0, then left line 0 (descending) with right line 1, then left line 1 (ascending).
    do_reset(4);
    send(4, 64'h2110, 0, 64'h0, 100, 100);
    send(4, 64'h3333, 4, 64'h2110, 100, 100);
    send(0, 64'h0, 4, 64'h3200, 100, 70);
    drain();

    // Threshold boundary: |2-3| accepted on line 0, |2-7| rejected on line 1, clken toggling.
    do_reset(5);
    send(5, 64'h00300, 0, 64'h0, 100, 100);
    send(5, 64'h00700, 5, 64'h00002, 60, 100);
    send(0, 64'h0, 5, 64'h20000, 60, 100);
    drain();

    // Reset mid-line with pixels in flight, then replay the width-4 sequence with clken gaps.
    do_reset(4);
    send(4, 64'h2110, 0, 64'h0, 100, 100);
    send(0, 64'h0, 2, 64'h10, 100, 100);
    do_reset(4);
    send(4, 64'h2110, 0, 64'h0, 70, 100);
    send(4, 64'h3333, 4, 64'h2110, 70, 100);
    send(0, 64'h0, 4, 64'h3200, 70, 80);
    drain();

    // Random lines at width 16.
    do_reset(16);
    rv = {$urandom, $urandom} & 64'h3333_3333_3333_3333;
    send(16, rv, 0, 64'h0, 80, 100);
    for (int l = 0; l < 6; l++) begin
      rv = {$urandom, $urandom} & 64'h3333_3333_3333_3333;
      lv = {$urandom, $urandom} & 64'h7777_7777_7777_7777;
      send(16, rv, 16, lv, 80, 80);
    end
    lv = {$urandom, $urandom} & 64'h7777_7777_7777_7777;
    send(0, 64'h0, 16, lv, 80, 80);
    drain();

    // Left pixels with no complete right line: ovr_err sets and stays set.
    do_reset(16);
    lv = {$urandom, $urandom} & 64'h7777_7777_7777_7777;
    send(0, 64'h0, 16, lv, 70, 100);
    send(0, 64'h0, 4, lv, 70, 100);
    drain();
    check("ovr_sticky", 32'(ovr_err), 32'd1);

    do_reset(4);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
